// File: rtl/pipe_ctrl_if.sv
// Handshake and control bundle between the pipeline datapath and its stall/flush controller.
// slave: the controller side; master: the datapath side that raises requests/hazards.
interface pipe_ctrl_if;
    logic        imem_req;
    logic        imem_resp;
    logic        dmem_req;
    logic        dmem_resp;
    logic        load_use;
    logic        br_mispredict;
    logic        pc_en;
    logic        en_if_id;
    logic        en_id_ex;
    logic        en_ex_mem;
    logic        en_mem_wb;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;

    modport master (
        output imem_req, imem_resp, dmem_req, dmem_resp, load_use, br_mispredict,
        input  pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
        input  flush_if_id, flush_id_ex, stall_cnt, bubble_cnt
    );

    modport slave (
        input  imem_req, imem_resp, dmem_req, dmem_resp, load_use, br_mispredict,
        output pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
        output flush_if_id, flush_id_ex, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: freezes all stages on memory waits, inserts bubbles/flushes on hazards.
// Latency: enables and flushes are combinational (0 cycles); counters update on the next clk edge.
// Backpressure: any outstanding memory request without a response holds every stage until both are satisfied.
module pipe_ctrl (
    input  logic   clk,
    input  logic   rst,
    pipe_ctrl_if.slave p
);
    typedef enum logic {RUN, STALL} state_t;

    state_t      state, state_nxt;
    logic        i_done, d_done;
    logic        i_ok, d_ok, advance;
    logic [31:0] stall_q, bubble_q;

    logic pc_en_c, en_if_id_c, en_id_ex_c, en_ex_mem_c, en_mem_wb_c;
    logic flush_if_id_c, flush_id_ex_c;

    // A response already seen during this stall keeps its side satisfied.
    assign i_ok    = !p.imem_req | p.imem_resp | i_done;
    assign d_ok    = !p.dmem_req | p.dmem_resp | d_done;
    assign advance = i_ok & d_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            stall_q  <= 32'd0;
            bubble_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (advance) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end else begin
                // Responses without a matching request are ignored.
                if (p.imem_req && p.imem_resp) i_done <= 1'b1;
                if (p.dmem_req && p.dmem_resp) d_done <= 1'b1;
            end
            if (!advance)
                stall_q <= stall_q + 32'd1;
            if (advance && (p.load_use || p.br_mispredict))
                bubble_q <= bubble_q + 32'd1;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_en_c       = 1'b0;
        en_if_id_c    = 1'b0;
        en_id_ex_c    = 1'b0;
        en_ex_mem_c   = 1'b0;
        en_mem_wb_c   = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;

        if (rst) begin
            state_nxt     = RUN;
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
        end else begin
            case (state)
                RUN:     if (!advance) state_nxt = STALL;
                STALL:   if (advance)  state_nxt = RUN;
                default: state_nxt = RUN;
            endcase

            if (advance) begin
                pc_en_c     = 1'b1;
                en_if_id_c  = 1'b1;
                en_id_ex_c  = 1'b1;
                en_ex_mem_c = 1'b1;
                en_mem_wb_c = 1'b1;
                // A redirect squashes the younger load-use victim, so it wins.
                if (p.br_mispredict) begin
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                end else if (p.load_use) begin
                    pc_en_c       = 1'b0;
                    en_if_id_c    = 1'b0;
                    flush_id_ex_c = 1'b1;
                end
            end
        end
    end

    assign p.pc_en       = pc_en_c;
    assign p.en_if_id    = en_if_id_c;
    assign p.en_id_ex    = en_id_ex_c;
    assign p.en_ex_mem   = en_ex_mem_c;
    assign p.en_mem_wb   = en_mem_wb_c;
    assign p.flush_if_id = flush_if_id_c;
    assign p.flush_id_ex = flush_id_ex_c;
    assign p.stall_cnt   = stall_q;
    assign p.bubble_cnt  = bubble_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: per-cycle expected controls and counters queued at drive time, compared mid-cycle.
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    pipe_ctrl_if pif();

    pipe_ctrl dut (.clk(clk), .rst(rst), .p(pif.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  ctl;     // {pc_en, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex}
        logic [31:0] stall;
        logic [31:0] bubble;
    } exp_t;

    exp_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    logic        m_idone, m_ddone;
    logic [31:0] m_stall, m_bubble;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive, predict, check mid-cycle, then advance the model on the edge.
    task automatic step(input logic r, input logic ir, input logic irs, input logic dr,
                        input logic drs, input logic lu, input logic mis, input string tag);
        logic adv;
        exp_t e;
        exp_t got;
        rst               = r;
        pif.imem_req      = ir;
        pif.imem_resp     = irs;
        pif.dmem_req      = dr;
        pif.dmem_resp     = drs;
        pif.load_use      = lu;
        pif.br_mispredict = mis;

        adv = (!ir || irs || m_idone) && (!dr || drs || m_ddone);
        if (r)          e.ctl = 7'b00000_11;
        else if (!adv)  e.ctl = 7'b00000_00;
        else if (mis)   e.ctl = 7'b11111_11;
        else if (lu)    e.ctl = 7'b00111_01;
        else            e.ctl = 7'b11111_00;
        e.stall  = m_stall;
        e.bubble = m_bubble;
        exp_q.push_back(e);

        @(negedge clk);
        got = exp_q.pop_front();
        check({tag, ".ctl"}, {25'd0, pif.pc_en, pif.en_if_id, pif.en_id_ex, pif.en_ex_mem,
                              pif.en_mem_wb, pif.flush_if_id, pif.flush_id_ex}, {25'd0, got.ctl});
        check({tag, ".stall_cnt"}, pif.stall_cnt, got.stall);
        check({tag, ".bubble_cnt"}, pif.bubble_cnt, got.bubble);

        @(posedge clk);
        if (r) begin
            m_idone = 1'b0; m_ddone = 1'b0; m_stall = 32'd0; m_bubble = 32'd0;
        end else begin
            if (!adv) m_stall = m_stall + 32'd1;
            if (adv && (lu || mis)) m_bubble = m_bubble + 32'd1;
            if (adv) begin
                m_idone = 1'b0; m_ddone = 1'b0;
            end else begin
                if (ir && irs) m_idone = 1'b1;
                if (dr && drs) m_ddone = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        logic ir, dr;
        m_idone = 1'b0; m_ddone = 1'b0; m_stall = 32'd0; m_bubble = 32'd0;
        rst = 1'b1;
        pif.imem_req = 0; pif.imem_resp = 0; pif.dmem_req = 0; pif.dmem_resp = 0;
        pif.load_use = 0; pif.br_mispredict = 0;
        @(posedge clk); #1;

        // Reset behaviour, including hazards present during reset.
        step(1, 0, 0, 0, 0, 0, 0, "rst0");
        step(1, 1, 0, 1, 0, 1, 1, "rst_haz");

        // Idle run.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, "idle");

        // Fetch wait of 3 cycles.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, "istall");
        step(0, 1, 1, 0, 0, 0, 0, "iresp");
        step(0, 0, 0, 0, 0, 0, 0, "post_i");

        // Both memories waiting, responses in cycles 1 and 4.
        step(0, 1, 0, 1, 0, 0, 0, "both0");
        step(0, 1, 1, 1, 0, 0, 0, "both1");
        step(0, 1, 0, 1, 0, 0, 0, "both2");
        step(0, 1, 0, 1, 0, 0, 0, "both3");
        step(0, 1, 0, 1, 1, 0, 0, "both4");
        step(0, 0, 0, 0, 0, 0, 0, "post_b");

        // Load-use bubble.
        step(0, 0, 0, 0, 0, 1, 0, "lu");
        step(0, 0, 0, 0, 0, 0, 0, "post_lu");

        // Mispredict alone.
        step(0, 0, 0, 0, 0, 0, 1, "mis");

        // Both hazards held across a 2-cycle data stall.
        step(0, 0, 0, 1, 0, 1, 1, "hz_st0");
        step(0, 0, 0, 1, 0, 1, 1, "hz_st1");
        step(0, 0, 0, 1, 1, 1, 1, "hz_adv");
        step(0, 0, 0, 0, 0, 0, 0, "post_hz");

        // Stray response with no request must not pre-satisfy the next fetch.
        step(0, 0, 1, 0, 1, 0, 0, "stray");
        step(0, 1, 0, 1, 0, 0, 0, "stray_req0");
        step(0, 1, 1, 1, 0, 0, 0, "stray_req1");
        step(0, 0, 0, 1, 1, 0, 0, "stray_done");

        // Reset in the middle of a stall with a fetch response already recorded.
        step(0, 1, 0, 1, 0, 0, 0, "mid0");
        step(0, 1, 1, 1, 0, 1, 0, "mid1");
        step(1, 1, 0, 1, 0, 1, 1, "mid_rst");
        step(0, 1, 0, 0, 0, 0, 0, "after_rst0");
        step(0, 1, 0, 0, 0, 0, 0, "after_rst1");
        step(0, 1, 1, 0, 0, 0, 0, "after_rst2");

        // Randomised traffic with sparse resets.
        ir = 0; dr = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) ir = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) dr = $urandom_range(0, 1);
            step(($urandom_range(0, 60) == 0),
                 ir, ($urandom_range(0, 2) == 0),
                 dr, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), "rand");
        end

        if (exp_q.size() != 0) check("sb_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
